// File: rtl/cpu_seq_ctrl_if.sv
// rtl/cpu_seq_ctrl_if.sv - instruction-ROM and datapath/data-memory bus of the CPU sequencer
//
// Signals:
//   pc        sequencer -> ROM       instruction address (ROM is combinational)
//   ins       ROM -> sequencer       instruction at pc, valid in the same cycle
//   acc_neg   datapath -> sequencer  accumulator sign bit
//   mem_ready memory -> sequencer    data memory can complete the access this cycle
//   acc_load  sequencer -> datapath  acc <= mem[data_addr]
//   acc_add   sequencer -> datapath  acc <= acc + mem[data_addr]
//   acc_shr   sequencer -> datapath  acc <= acc >> 1
//   mem_we    sequencer -> memory    mem[data_addr] <= acc
//   data_addr sequencer -> memory    operand field of the latched instruction
// master: the sequencer.  slave: the ROM/datapath/memory side.
interface cpu_seq_ctrl_if;
    logic [7:0]  pc;
    logic [11:0] ins;
    logic        acc_neg;
    logic        mem_ready;
    logic        acc_load;
    logic        acc_add;
    logic        acc_shr;
    logic        mem_we;
    logic [7:0]  data_addr;

    modport master (
        output pc, acc_load, acc_add, acc_shr, mem_we, data_addr,
        input  ins, acc_neg, mem_ready
    );

    modport slave (
        input  pc, acc_load, acc_add, acc_shr, mem_we, data_addr,
        output ins, acc_neg, mem_ready
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - fetch/decode/execute sequencer for the 8-bit-address 12-bit-instruction CPU
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    one-cycle pulse, (re)starts execution at START_ADDR from IDLE or HALT
//   bus      master side of cpu_seq_ctrl_if (ROM address/data, strobes, mem_ready, acc_neg)
//   ir       latched instruction
//   busy     high in FETCH, DECODE and EXEC
//   halted   high in HALT
//   retired  saturating count of completed instructions
module cpu_seq_ctrl #(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    cpu_seq_ctrl_if.master      bus,
    output logic [11:0]         ir,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_BAN = 4'hC;
    localparam logic [3:0] OP_SHR = 4'hD;
    localparam logic [3:0] OP_STP = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [11:0]        ir_q, ir_d;
    logic [7:0]         addr_q, addr_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    logic [3:0]         op;
    logic               needs_mem;
    logic               exec_done;

    assign op        = ir_q[11:8];
    assign needs_mem = (op == OP_LDA) || (op == OP_ADD) || (op == OP_STA);
    // The instruction completes in the EXEC cycle where memory is ready,
    // or immediately for opcodes that do not touch data memory.
    assign exec_done = (state_q == ST_EXEC) && (!needs_mem || bus.mem_ready);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        ret_d    = ret_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = START_ADDR;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.ins;
                addr_d  = bus.ins[7:0];
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (ret_q != CNT_MAX) begin
                        ret_d = ret_q + CNT_ONE;
                    end
                    state_d = ST_FETCH;
                    unique case (op)
                        OP_JMP:  pc_d = ir_q[7:0];
                        OP_BAN:  pc_d = bus.acc_neg ? ir_q[7:0] : pc_q + 8'd1;
                        OP_STP:  state_d = ST_HALT;
                        default: pc_d = pc_q + 8'd1;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) || (state_d == ST_EXEC);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= START_ADDR;
            ir_q     <= 12'h000;
            addr_q   <= 8'h00;
            ret_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            addr_q   <= addr_d;
            ret_q    <= ret_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // Strobes are decoded from registered state and ir, gated by mem_ready in
    // the same cycle, so the datapath acts exactly in the cycle memory is ready.
    // Reset forces IDLE, which drops any pending strobe immediately.
    assign bus.acc_load  = exec_done && (op == OP_LDA);
    assign bus.acc_add   = exec_done && (op == OP_ADD);
    assign bus.acc_shr   = exec_done && (op == OP_SHR);
    assign bus.mem_we    = exec_done && (op == OP_STA);

    assign bus.pc        = pc_q;
    assign bus.data_addr = addr_q;
    assign ir            = ir_q;
    assign busy          = busy_q;
    assign halted        = halted_q;
    assign retired       = ret_q;

endmodule
